// File: rtl/collision_frame_arbiter.sv
// rtl/collision_frame_arbiter.sv - frame-accumulated border/overlap collision arbiter
// Gathers collision evidence over a video frame and reports it as one-cycle pulses after startOfFrame.
module collision_frame_arbiter #(
    parameter int NUM_BUBBLES  = 4,
    parameter int LEFT_BORDER  = 0,
    parameter int RIGHT_BORDER = 639,
    parameter int TOP_BORDER   = 0,
    parameter int OVERLAP_MIN  = 4,
    parameter int POP_CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic                   charDrawingRequest,
    input  logic                   arrowDrawingRequest,
    input  logic [NUM_BUBBLES-1:0] bubbleDrawingRequest,
    output logic                   charCrashLeft,
    output logic                   charCrashRight,
    output logic                   arrowHitTop,
    output logic [NUM_BUBBLES-1:0] bubbleHitChar,
    output logic [NUM_BUBBLES-1:0] arrowHitBubble,
    output logic [POP_CNT_W-1:0]   popCount
);
    localparam int OV_W = $clog2(OVERLAP_MIN + 1);
    localparam logic [10:0]     LEFT_LIM  = 11'(LEFT_BORDER);
    localparam logic [10:0]     RIGHT_LIM = 11'(RIGHT_BORDER);
    localparam logic [10:0]     TOP_LIM   = 11'(TOP_BORDER);
    localparam logic [OV_W-1:0] OV_MAX    = OV_W'(OVERLAP_MIN);

    logic                   leftAcc, rightAcc, topAcc, armed;
    logic [NUM_BUBBLES-1:0] arrowAcc;
    logic [OV_W-1:0]        ovCnt [NUM_BUBBLES];

    logic                   leftNow, rightNow, topNow;
    logic [NUM_BUBBLES-1:0] arrowNow, overlapNow, charHit, popPick;

    always_comb begin
        leftNow    = charDrawingRequest && (pixelX <= LEFT_LIM);
        rightNow   = charDrawingRequest && (pixelX >= RIGHT_LIM);
        topNow     = arrowDrawingRequest && (pixelY <= TOP_LIM);
        arrowNow   = arrowDrawingRequest ? bubbleDrawingRequest : '0;
        overlapNow = charDrawingRequest ? bubbleDrawingRequest : '0;
        for (int i = 0; i < NUM_BUBBLES; i++) begin
            charHit[i] = (ovCnt[i] == OV_MAX);
        end
        // Isolate the lowest set bit so at most one bubble pops per frame.
        popPick = arrowAcc & (~arrowAcc + 1'b1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leftAcc        <= 1'b0;
            rightAcc       <= 1'b0;
            topAcc         <= 1'b0;
            armed          <= 1'b0;
            arrowAcc       <= '0;
            for (int i = 0; i < NUM_BUBBLES; i++) ovCnt[i] <= '0;
            charCrashLeft  <= 1'b0;
            charCrashRight <= 1'b0;
            arrowHitTop    <= 1'b0;
            bubbleHitChar  <= '0;
            arrowHitBubble <= '0;
            popCount       <= '0;
        end else begin
            charCrashLeft  <= 1'b0;
            charCrashRight <= 1'b0;
            arrowHitTop    <= 1'b0;
            bubbleHitChar  <= '0;
            arrowHitBubble <= '0;
            if (startOfFrame) begin
                armed <= 1'b1;
                // The first frame after reset is partial and is dropped silently.
                if (armed) begin
                    charCrashLeft  <= leftAcc;
                    charCrashRight <= rightAcc;
                    arrowHitTop    <= topAcc;
                    bubbleHitChar  <= charHit;
                    arrowHitBubble <= popPick;
                    if (popPick != '0 && popCount != '1) popCount <= popCount + 1'b1;
                end
                // The SOF pixel itself starts the new frame.
                leftAcc  <= leftNow;
                rightAcc <= rightNow;
                topAcc   <= topNow;
                arrowAcc <= arrowNow;
                for (int i = 0; i < NUM_BUBBLES; i++) begin
                    ovCnt[i] <= overlapNow[i] ? OV_W'(1) : '0;
                end
            end else begin
                leftAcc  <= leftAcc | leftNow;
                rightAcc <= rightAcc | rightNow;
                topAcc   <= topAcc | topNow;
                arrowAcc <= arrowAcc | arrowNow;
                for (int i = 0; i < NUM_BUBBLES; i++) begin
                    if (overlapNow[i] && ovCnt[i] != OV_MAX) ovCnt[i] <= ovCnt[i] + 1'b1;
                end
            end
        end
    end
endmodule
